// File: rtl/i2c_tx_bit_sequencer.sv
// Transmit-side I2C bit sequencer: latches a byte, walks the 8:1 mux select MSB first,
// generates SCL phases from a clock divider, then releases SDA for the ACK clock.
module i2c_tx_bit_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       sda_in,
  output logic [7:0] byte_q,
  output logic [2:0] sel,
  output logic       scl_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LOW  = 3'd1,
    BIT_HIGH = 3'd2,
    ACK_LOW  = 3'd3,
    ACK_HIGH = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div;
  logic       phase_end;

  // The bit index saturates at 0 so it can never wrap back to 7 mid-byte.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  assign phase_end = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      byte_q  <= 8'h00;
      sel     <= 3'd7;
      scl_out <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_ok  <= 1'b0;
      div     <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          scl_out <= 1'b1;
          sda_oe  <= 1'b0;
          div     <= 8'd0;
          if (start) begin
            byte_q  <= data_in;
            sel     <= 3'd7;
            busy    <= 1'b1;
            scl_out <= 1'b0;
            sda_oe  <= 1'b1;
            state   <= BIT_LOW;
          end
        end
        BIT_LOW: begin
          if (phase_end) begin
            div     <= 8'd0;
            scl_out <= 1'b1;
            state   <= BIT_HIGH;
          end else begin
            div <= div + 8'd1;
          end
        end
        BIT_HIGH: begin
          // sel only moves on the edge back into BIT_LOW, so data is stable while SCL is high.
          if (phase_end) begin
            div     <= 8'd0;
            scl_out <= 1'b0;
            if (sel == 3'd0) begin
              sda_oe <= 1'b0;
              state  <= ACK_LOW;
            end else begin
              sel   <= sat_dec(sel);
              state <= BIT_LOW;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        ACK_LOW: begin
          if (phase_end) begin
            div     <= 8'd0;
            scl_out <= 1'b1;
            state   <= ACK_HIGH;
          end else begin
            div <= div + 8'd1;
          end
        end
        ACK_HIGH: begin
          // A slave acknowledges by holding SDA low through the ACK clock.
          if (phase_end) begin
            div    <= 8'd0;
            ack_ok <= ~sda_in;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            div <= div + 8'd1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          sel     <= 3'd7;
          scl_out <= 1'b1;
          sda_oe  <= 1'b0;
          div     <= 8'd0;
          state   <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          sel     <= 3'd7;
          scl_out <= 1'b1;
          sda_oe  <= 1'b0;
          div     <= 8'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_tx_bit_sequencer.sv
// Bench for i2c_tx_bit_sequencer: two instances (CLK_DIV 4 and 1) checked against a
// per-cycle timing model plus a scoreboard of expected serial bits and byte results.
module tb_i2c_tx_bit_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, use1, sda_in;
  logic [7:0] data_in;
  logic       start4, start1;

  logic [7:0] bq4, bq1;
  logic [2:0] sel4, sel1;
  logic       scl4, scl1, oe4, oe1, busy4, busy1, done4, done1, ack4, ack1;

  assign start4 = start & ~use1;
  assign start1 = start & use1;

  i2c_tx_bit_sequencer #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data_in(data_in), .sda_in(sda_in),
    .byte_q(bq4), .sel(sel4), .scl_out(scl4), .sda_oe(oe4), .busy(busy4),
    .done(done4), .ack_ok(ack4)
  );

  i2c_tx_bit_sequencer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in), .sda_in(sda_in),
    .byte_q(bq1), .sel(sel1), .scl_out(scl1), .sda_oe(oe1), .busy(busy1),
    .done(done1), .ack_ok(ack1)
  );

  logic [7:0] bq_o;
  logic [2:0] sel_o;
  logic       scl_o, oe_o, busy_o, done_o, ack_o;
  logic [6:0] obs_vec;

  always_comb begin
    bq_o = bq4; sel_o = sel4; scl_o = scl4; oe_o = oe4;
    busy_o = busy4; done_o = done4; ack_o = ack4;
    if (use1) begin
      bq_o = bq1; sel_o = sel1; scl_o = scl1; oe_o = oe1;
      busy_o = busy1; done_o = done1; ack_o = ack1;
    end
  end

  assign obs_vec = {scl_o, oe_o, busy_o, done_o, sel_o};

  typedef struct {
    logic [7:0] d;
    logic       ack;
    int         cyc;
  } done_t;

  int    tests = 0;
  int    failed = 0;
  int    cyc;
  logic  prev_scl;
  logic  last_ack [2];
  logic  bitq [$];
  done_t doneq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {scl, sda_oe, busy, done, sel} for cycle c of a transfer (cycle 0 = start sampled).
  function automatic logic [6:0] model(input int c, input int div);
    logic s, o, b, dn;
    logic [2:0] sl;
    int ph;
    s = 1'b1; o = 1'b0; b = 1'b0; dn = 1'b0; sl = 3'd7;
    if (c >= 1 && c <= 16 * div) begin
      ph = (c - 1) / div;
      s  = (ph % 2) == 1;
      o  = 1'b1;
      b  = 1'b1;
      sl = 3'(7 - (c - 1) / (2 * div));
    end else if (c > 16 * div && c <= 18 * div) begin
      ph = (c - 1) / div;
      s  = (ph % 2) == 1;
      b  = 1'b1;
      sl = 3'd0;
    end else if (c == 18 * div + 1) begin
      b  = 1'b1;
      dn = 1'b1;
      sl = 3'd0;
    end
    return {s, o, b, dn, sl};
  endfunction

  task automatic run_byte(input logic [7:0] d, input logic ack, input bit d1,
                          input bit poke, input int rst_at);
    int    div, last;
    bit    seen;
    done_t e;
    div  = d1 ? 1 : 4;
    last = 18 * div + 1;
    use1 = d1;
    for (int i = 7; i >= 0; i--) bitq.push_back(d[i]);
    doneq.push_back('{d, ~ack, last});
    data_in = d;
    sda_in  = ~ack;
    start   = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    prev_scl = 1'b1;
    seen     = 1'b0;
    chk("ack_hold", ack_o, last_ack[d1]);
    while (!seen && cyc <= last + 4) begin
      chk($sformatf("vec_c%0d", cyc), obs_vec, model(cyc, div));
      if (!prev_scl && scl_o && oe_o) begin
        if (bitq.size() == 0) chk("extra_bit", bitq.size(), 1);
        else chk($sformatf("y_sel%0d", sel_o), bq_o[sel_o], bitq.pop_front());
      end
      if (done_o) begin
        seen = 1'b1;
        if (doneq.size() == 0) begin
          chk("extra_done", doneq.size(), 1);
        end else begin
          e = doneq.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("byte_q", bq_o, e.d);
          chk("ack_ok", ack_o, e.ack);
          chk("bits_left", bitq.size(), 0);
          last_ack[d1] = e.ack;
        end
      end
      if (rst_at != 0 && cyc == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_vec", obs_vec, 7'b1000111);
        chk("rst_byte_q", bq_o, 8'h00);
        chk("rst_ack_ok", ack_o, 1'b0);
        bitq.delete();
        doneq.delete();
        last_ack[0] = 1'b0;
        last_ack[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("rst_no_done", {busy_o, done_o}, 2'b00);
        end
        return;
      end
      prev_scl = scl_o;
      sda_in = (cyc > 16 * div && cyc <= 18 * div) ? ack : ~ack;
      if (poke && (cyc == 10 || seen)) begin
        start   = 1'b1;
        data_in = ~d;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("done_seen", seen, 1'b1);
    start = 1'b0;
    chk("idle_vec", obs_vec, 7'b1000111);
    chk("idle_byte_q", bq_o, d);
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("no_requeue", {busy_o, scl_o, bq_o}, {2'b01, d});
      end
    end
  endtask

  initial begin
    use1 = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    data_in = 8'h00;
    sda_in = 1'b1;
    last_ack[0] = 1'b0;
    last_ack[1] = 1'b0;
    tick();
    tick();
    chk("reset_vec4", obs_vec, 7'b1000111);
    chk("reset_bq4", {bq_o, ack_o}, 9'h000);
    use1 = 1'b1;
    #1;
    chk("reset_vec1", obs_vec, 7'b1000111);
    chk("reset_bq1", {bq_o, ack_o}, 9'h000);
    use1 = 1'b0;
    data_in = 8'hC3;
    start = 1'b1;
    tick();
    chk("rst_beats_start", obs_vec, 7'b1000111);
    chk("rst_beats_start_bq", bq_o, 8'h00);
    rst = 1'b0;
    start = 1'b0;
    tick();

    run_byte(8'h5C, 1'b0, 1'b0, 1'b0, 0);
    run_byte(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    run_byte(8'h3C, 1'b0, 1'b0, 1'b1, 0);
    run_byte(8'h96, 1'b0, 1'b0, 1'b0, 30);
    run_byte(8'h5C, 1'b0, 1'b0, 1'b0, 0);
    run_byte(8'hFF, 1'b0, 1'b1, 1'b0, 0);
    run_byte(8'h81, 1'b1, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2c_tx_bit_sequencer.md
# i2c_tx_bit_sequencer

Transmit-side bit sequencer for the I2C master. It latches one byte and generates the SCL phase timing. It drives the byte and a 3-bit select into the downstream 8:1 mux (`V`/`S` inputs), so the mux output `Y` is the serial SDA data bit, sent MSB first. After the 8 data bits it releases SDA for one ACK clock, samples the slave's acknowledge and reports completion.

## Interface

**Parameters**
- `CLK_DIV`, default 4: system clocks per SCL half-period. Legal range 1..255. The divider counter is 8 bits wide.

**Ports**
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request to send a byte. Sampled only in IDLE.
- `data_in` input 8: byte to send. Captured on the cycle `start` is accepted.
- `sda_in` input 1: sampled SDA line, used for the ACK bit.
- `byte_q` output 8: latched byte. Drives mux `V`.
- `sel` output 3: bit index. Drives mux `S`; the mux output `Y` = `byte_q[sel]`.
- `scl_out` output 1: SCL level (1 = released/high).
- `sda_oe` output 1: 1 = SDA driven from mux `Y`; 0 = SDA released.
- `busy` output 1: high from start acceptance until the end of DONE.
- `done` output 1: one-cycle pulse at the end of the byte.
- `ack_ok` output 1: 1 = slave pulled SDA low in the ACK slot. Holds until the next byte completes.

## Operation

- States: IDLE, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH, DONE. All outputs are registered.
- Reset values:
  - state = IDLE
  - `byte_q` = 0x00
  - `sel` = 7
  - `scl_out` = 1
  - `sda_oe` = 0
  - `busy` = 0
  - `done` = 0
  - `ack_ok` = 0
  - divider = 0
- IDLE:
  - Outputs: `scl_out` = 1, `sda_oe` = 0.
  - On `start` = 1: `byte_q` <= `data_in`, `sel` <= 7, `busy` <= 1, divider <= 0, go to BIT_LOW.
- BIT_LOW:
  - Outputs: `scl_out` = 0, `sda_oe` = 1.
  - Lasts `CLK_DIV` cycles, then go to BIT_HIGH with divider <= 0.
- BIT_HIGH:
  - Outputs: `scl_out` = 1, `sda_oe` = 1.
  - Lasts `CLK_DIV` cycles.
  - On the last cycle: if `sel` == 0, go to ACK_LOW; otherwise `sel` <= `sel` - 1 and go to BIT_LOW.
  - `sel` never wraps below 0.
- ACK_LOW:
  - Outputs: `scl_out` = 0, `sda_oe` = 0.
  - Lasts `CLK_DIV` cycles, then go to ACK_HIGH.
- ACK_HIGH:
  - Outputs: `scl_out` = 1, `sda_oe` = 0.
  - Lasts `CLK_DIV` cycles.
  - On the last cycle: `ack_ok` <= ~`sda_in`, go to DONE.
- DONE:
  - One cycle with `done` = 1, `scl_out` = 1, `sda_oe` = 0, `busy` = 1.
  - Next cycle: IDLE with `busy` = 0, `done` = 0, `sel` <= 7.
- Divider: counts 0..`CLK_DIV`-1 within each phase state and clears on every phase transition.
- `sel` and `byte_q` change only while SCL is low or on a state change into BIT_LOW. Data is never altered while `scl_out` = 1.

## Timing

- Cycle numbering: cycle 0 is the cycle `start` is sampled in IDLE.
- BIT_LOW for bit 7 starts at cycle 1.
- Each data bit occupies 2·`CLK_DIV` cycles. The ACK slot occupies 2·`CLK_DIV` cycles.
- DONE is at cycle 18·`CLK_DIV` + 1. With `CLK_DIV` = 4, `done` is high at cycle 73 only.
- Minimum start-to-start interval: 18·`CLK_DIV` + 2 cycles.
- `sel` = 7−k throughout bit k (k = 0..7), including both its LOW and HIGH phases.
- Boundary and simultaneous-event rules:
  - `start` while `busy` = 1, including in the DONE cycle: ignored, no queuing.
  - `start` held high continuously: the next byte is accepted in the first IDLE cycle.
  - `data_in` changes while busy: no effect.
  - `rst` in any state, including mid-bit: on the next edge, all outputs take their reset values. No `done` pulse is produced and `ack_ok` is cleared.
  - `rst` and `start` both high: `rst` wins.
  - `CLK_DIV` = 1: each phase lasts exactly 1 cycle and the byte takes 19 cycles to DONE.

## Test plan

- **Reset:** assert `rst` 2 cycles → `scl_out` = 1, `sda_oe` = 0, `sel` = 7, `busy` = 0, `done` = 0, `ack_ok` = 0, `byte_q` = 0x00.
- **Byte 0x5C with ACK, `CLK_DIV` = 4:**
  - Stimulus: `data_in` = 8'b01011100, `start` pulse, `sda_in` = 0 in the ACK slot.
  - Required: `sel` steps 7,6,…,0 every 8 cycles. Mux `Y` during the high phases = 0,1,0,1,1,1,0,0. `scl_out` toggles every 4 cycles. `done` pulses at cycle 73. `ack_ok` = 1.
- **NACK:** byte 0xA5 with `sda_in` = 1 in ACK_HIGH → `ack_ok` = 0, `done` pulses at cycle 73, `sda_oe` = 0 during cycles 65–72.
- **Start while busy:** second `start` at cycles 10 and 73 with a different `data_in` → `byte_q` unchanged; returns to IDLE at cycle 74; no second transfer begins without a new `start`.
- **Reset mid-byte:** `rst` at cycle 30 → reset values next cycle and no `done` pulse. A fresh `start` then completes normally.
- **`CLK_DIV` = 1:** byte 0xFF, ACK = 0 → `sel` decrements every 2 cycles, `done` at cycle 19, `ack_ok` = 1.
